seq_gen_101: RTL and testbench

//  Serial pattern transmitter: the generating end of the serial bit-pattern detectors.
//  On a start pulse it emits a PAT_W-bit pattern MSB-first, one bit per clock.
//  The pattern is repeated repeat_n times, with gap_n idle bits between repetitions.

---
 rtl/seq_gen_101_if.sv | 28 ++
 rtl/seq_gen_101.sv | 112 +++++++++++
 tb/tb_seq_gen_101.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seq_gen_101_if.sv
// Bundle between a serial pattern generator and whatever requests bursts from it.
// The master side issues burst requests; the slave side is the generator.
interface seq_gen_101_if #(
   parameter int PAT_W = 3,
   parameter int CNT_W = 4
);
   // Request/acknowledge: a start pulse sampled while busy=0 with repeat_n!=0 is accepted
   // on that edge; busy then stays high until the done cycle ends, and any start
   // seen while busy=1 (or with repeat_n==0) is dropped, so there is no backpressure.
   logic             start;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] repeat_n;
   logic [CNT_W-1:0] gap_n;
   logic             out_bit;
   logic             out_valid;
   logic             busy;
   logic             done;

   modport master (
      output start, pattern, repeat_n, gap_n,
      input  out_bit, out_valid, busy, done
   );

   modport slave (
      input  start, pattern, repeat_n, gap_n,
      output out_bit, out_valid, busy, done
   );
endinterface

// File: rtl/seq_gen_101.sv
// Serial pattern transmitter: emits a latched pattern MSB-first, repeat_n times,
// with gap_n idle bits between repetitions, then pulses done.
module seq_gen_101 #(
   parameter int   PAT_W    = 3,
   parameter int   CNT_W    = 4,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   seq_gen_101_if.slave bus,
   output logic [1:0]   dbg_state
);
   localparam int BW = $clog2(PAT_W);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]       state;
   logic [PAT_W-1:0] pat_q;
   logic [PAT_W-1:0] shreg;
   logic [BW-1:0]    bit_left;
   logic [CNT_W-1:0] rep_left;
   logic [CNT_W-1:0] gap_q;
   logic [CNT_W-1:0] gap_cnt;
   logic [CNT_W-1:0] rep_dec;

   // rep_left is never zero while in SHIFT/GAP, so this cannot wrap.
   always_comb begin
      rep_dec = rep_left - CNT_W'(1);
   end

   assign dbg_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         pat_q         <= '0;
         shreg         <= '0;
         bit_left      <= '0;
         rep_left      <= '0;
         gap_q         <= '0;
         gap_cnt       <= '0;
         bus.out_bit   <= IDLE_BIT;
         bus.out_valid <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               bus.done <= 1'b0;
               if (bus.start && (bus.repeat_n != '0)) begin
                  state         <= ST_SHIFT;
                  pat_q         <= bus.pattern;
                  gap_q         <= bus.gap_n;
                  rep_left      <= bus.repeat_n;
                  shreg         <= {bus.pattern[PAT_W-2:0], 1'b0};
                  bit_left      <= BW'(PAT_W - 1);
                  bus.out_bit   <= bus.pattern[PAT_W-1];
                  bus.out_valid <= 1'b1;
                  bus.busy      <= 1'b1;
               end
            end

            ST_SHIFT: begin
               if (bit_left != '0) begin
                  bus.out_bit <= shreg[PAT_W-1];
                  shreg       <= {shreg[PAT_W-2:0], 1'b0};
                  bit_left    <= bit_left - BW'(1);
               end else begin
                  // The LSB is on the wire now: this edge closes one repetition.
                  rep_left <= rep_dec;
                  if (rep_dec == '0) begin
                     state         <= ST_DONE;
                     bus.out_bit   <= IDLE_BIT;
                     bus.out_valid <= 1'b0;
                     bus.done      <= 1'b1;
                  end else if (gap_q == '0) begin
                     shreg       <= {pat_q[PAT_W-2:0], 1'b0};
                     bit_left    <= BW'(PAT_W - 1);
                     bus.out_bit <= pat_q[PAT_W-1];
                  end else begin
                     state       <= ST_GAP;
                     gap_cnt     <= gap_q - CNT_W'(1);
                     bus.out_bit <= IDLE_BIT;
                  end
               end
            end

            ST_GAP: begin
               if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - CNT_W'(1);
               end else begin
                  state       <= ST_SHIFT;
                  shreg       <= {pat_q[PAT_W-2:0], 1'b0};
                  bit_left    <= BW'(PAT_W - 1);
                  bus.out_bit <= pat_q[PAT_W-1];
               end
            end

            default: begin
               state         <= ST_IDLE;
               bus.done      <= 1'b0;
               bus.busy      <= 1'b0;
               bus.out_valid <= 1'b0;
               bus.out_bit   <= IDLE_BIT;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_gen_101.sv
// Directed bench for seq_gen_101: table of bursts with hand-computed bit streams,
// plus hand-written sequences for reset abort, ignored requests and maximum counts.
module tb_seq_gen_101;
   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;

   seq_gen_101_if #(.PAT_W(3), .CNT_W(4)) bus ();

   seq_gen_101 #(.PAT_W(3), .CNT_W(4), .IDLE_BIT(1'b0)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  pattern;
      logic [3:0]  rep;
      logic [3:0]  gap;
      logic [31:0] bits;
      int          len;
      int          det;
      bit          poke;
   } vec_t;

   vec_t vecs[7];
   int   n_vec = 0;
   int   n_bad = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge of the first idle cycle after done.
   task automatic run_burst(input vec_t v);
      logic [2:0] hist;
      int         nv;
      int         det;
      hist = '0;
      nv   = 0;
      det  = 0;
      exp_q.delete();
      for (int i = v.len - 1; i >= 0; i--) exp_q.push_back({31'd0, v.bits[i]});
      bus.pattern  = v.pattern;
      bus.repeat_n = v.rep;
      bus.gap_n    = v.gap;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 1; i <= v.len; i++) begin
         if (i > 1) @(negedge clk);
         if (v.poke && i == 3) bus.start = 1'b0;
         chk("valid", {31'd0, bus.out_valid}, 32'd1);
         chk("bit", {31'd0, bus.out_bit}, exp_q.pop_front());
         chk("busy", {31'd0, bus.busy}, 32'd1);
         chk("done_early", {31'd0, bus.done}, 32'd0);
         if (bus.out_valid) begin
            hist = {hist[1:0], bus.out_bit};
            nv++;
            if (nv >= 3 && hist == 3'b101) det++;
         end
         if (v.poke && i == 2) begin
            bus.start    = 1'b1;
            bus.pattern  = 3'b010;
            bus.repeat_n = 4'd15;
            bus.gap_n    = 4'd7;
         end
      end
      @(negedge clk);
      chk("done", {31'd0, bus.done}, 32'd1);
      chk("done_busy", {31'd0, bus.busy}, 32'd1);
      chk("done_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("done_bit", {31'd0, bus.out_bit}, 32'd0);
      chk("detections", det, v.det);
      @(negedge clk);
      chk("idle_done", {31'd0, bus.done}, 32'd0);
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);
   endtask

   initial begin
      int nvalid;
      int ndone;
      int last_valid;
      int done_cyc;

      vecs[0] = '{3'b101, 4'd1, 4'd0, 32'b101,         3,  1, 1'b0};
      vecs[1] = '{3'b101, 4'd1, 4'd0, 32'b101,         3,  1, 1'b1};
      vecs[2] = '{3'b101, 4'd3, 4'd0, 32'b101101101,   9,  3, 1'b0};
      vecs[3] = '{3'b101, 4'd2, 4'd2, 32'b10100101,    8,  2, 1'b0};
      vecs[4] = '{3'b110, 4'd2, 4'd1, 32'b1100110,     7,  0, 1'b1};
      vecs[5] = '{3'b011, 4'd1, 4'd5, 32'b011,         3,  0, 1'b0};
      vecs[6] = '{3'b100, 4'd3, 4'd1, 32'b10001000100, 11, 0, 1'b0};

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.pattern  = '0;
      bus.repeat_n = '0;
      bus.gap_n    = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_bit", {31'd0, bus.out_bit}, 32'd0);
      chk("rst_state", {30'd0, dbg_state}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back: each burst starts in the idle cycle right after the previous done.
      for (int k = 0; k < 7; k++) run_burst(vecs[k]);

      // repeat_n == 0 is ignored entirely.
      bus.pattern  = 3'b101;
      bus.repeat_n = 4'd0;
      bus.gap_n    = 4'd0;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("rep0_busy", {31'd0, bus.busy}, 32'd0);
         chk("rep0_valid", {31'd0, bus.out_valid}, 32'd0);
         chk("rep0_done", {31'd0, bus.done}, 32'd0);
         @(negedge clk);
      end

      // Asynchronous reset in the middle of bit 2 of a three-repeat burst.
      bus.pattern  = 3'b101;
      bus.repeat_n = 4'd3;
      bus.gap_n    = 4'd0;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk("abort_bit2", {31'd0, bus.out_bit}, 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("abort_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_state", {30'd0, dbg_state}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_done", {31'd0, bus.done}, 32'd0);
         chk("abort_no_valid", {31'd0, bus.out_valid}, 32'd0);
      end
      run_burst(vecs[0]);

      // Maximum counts: 15*3 + 14*15 = 255 valid cycles, done on cycle 256.
      nvalid     = 0;
      ndone      = 0;
      last_valid = 0;
      done_cyc   = 0;
      bus.pattern  = 3'b101;
      bus.repeat_n = 4'd15;
      bus.gap_n    = 4'd15;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         if (c > 1) @(negedge clk);
         if (bus.out_valid) begin
            nvalid++;
            last_valid = c;
         end
         if (bus.done) begin
            ndone++;
            done_cyc = c;
         end
      end
      chk("max_valid_count", nvalid, 255);
      chk("max_last_valid", last_valid, 255);
      chk("max_done_count", ndone, 1);
      chk("max_done_cycle", done_cyc, 256);
      chk("max_busy_end", {31'd0, bus.busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
